ldm_stm_sequencer: RTL and testbench

//  Multi-cycle sequencer for ARM LDM/STM (block transfer). Sits upstream of the register

---
 rtl/ldm_stm_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for ARM LDM/STM: walks reg_list lowest register first,
// one register per cycle, then optionally writes the updated base back.
module ldm_stm_sequencer #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              incr,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [NREGS-1:0]  reg_list,
    output logic [3:0]        ra,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [3:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    output logic              pc_wr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: start is a one-cycle request taken only while busy=0; while
    // busy=1 the core stalls and further starts are dropped.

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WB = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [NREGS-1:0]    mask_q, mask_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   final_q, final_d;
    logic                load_q, load_d;
    logic                wb_q, wb_d;
    logic                supp_q, supp_d;
    logic [3:0]          base_q, base_d;
    logic                done_q, done_d;

    logic [3:0]          cur;
    logic [NREGS-1:0]    mask_rest;
    logic [DATA_W-1:0]   span;

    function automatic logic [DATA_W-1:0] popcount(input logic [NREGS-1:0] v);
        logic [DATA_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) cnt = cnt + DATA_W'(v[i]);
        return cnt;
    endfunction

    always_comb begin
        cur = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) cur = i[3:0];
        end
    end

    // x & (x-1) drops the lowest set bit, i.e. the register being moved now.
    assign mask_rest = mask_q & (mask_q - NREGS'(1));
    assign span      = popcount(reg_list) << 2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            supp_q  <= 1'b0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            final_q <= final_d;
            load_q  <= load_d;
            wb_q    <= wb_d;
            supp_q  <= supp_d;
            base_q  <= base_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        final_d = final_q;
        load_d  = load_q;
        wb_d    = wb_q;
        supp_d  = supp_q;
        base_d  = base_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_d = is_load;
                    wb_d   = writeback;
                    base_d = base_reg;
                    supp_d = is_load & reg_list[base_reg];
                    mask_d = reg_list;
                    if (incr) begin
                        addr_d  = base_addr;
                        final_d = base_addr + span;
                    end else begin
                        addr_d  = base_addr - span;
                        final_d = base_addr - span;
                    end
                    if (reg_list == '0) done_d = 1'b1;
                    else                state_d = XFER;
                end
            end
            XFER: begin
                mask_d = mask_rest;
                addr_d = addr_q + DATA_W'(4);
                if (mask_rest == '0) begin
                    if (wb_q) begin
                        state_d = WB;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ra       = '0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        rf_wa    = '0;
        rf_wd    = '0;
        rf_we    = 1'b0;
        case (state_q)
            XFER: begin
                mem_addr = addr_q;
                if (load_q) begin
                    rf_wa = cur;
                    rf_wd = mem_rd;
                    rf_we = 1'b1;
                end else begin
                    ra     = cur;
                    mem_wd = rd_data;
                    mem_we = 1'b1;
                end
            end
            WB: begin
                // A base register that was also loaded keeps the loaded value.
                rf_wa = base_q;
                rf_wd = final_q;
                rf_we = ~supp_q;
            end
            default: ;
        endcase
    end

    assign pc_wr     = rf_we && (rf_wa == 4'hF);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: regfile and memory live here, every cycle is checked
// against a list-driven transfer model, and final array contents are compared.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, is_load, incr, writeback;
    logic [3:0]  base_reg, ra, rf_wa;
    logic [31:0] base_addr, rd_data, mem_addr, mem_wd, mem_rd, rf_wd;
    logic [15:0] reg_list;
    logic        mem_we, rf_we, pc_wr, busy, done;
    logic [1:0]  dbg_state;

    logic [31:0] rf [16];
    logic [31:0] mem[256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ldm_stm_sequencer #(.DATA_W(32), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .incr(incr),
        .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr),
        .reg_list(reg_list), .ra(ra), .rd_data(rd_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .rf_wa(rf_wa),
        .rf_wd(rf_wd), .rf_we(rf_we), .pc_wr(pc_wr), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    assign rd_data = rf[ra];
    assign mem_rd  = mem[mem_addr[9:2]];

    // {busy, done, mem_we, mem_addr, mem_wd, ra, rf_we, rf_wa, rf_wd, pc_wr}
    function automatic logic [108:0] obs();
        return {busy, done, mem_we, mem_addr, mem_wd, ra, rf_we, rf_wa, rf_wd, pc_wr};
    endfunction

    task automatic init_env();
        for (int i = 0; i < 16; i++)  rf[i]  = $urandom;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic idle_inputs();
        start = 1'b0; is_load = 1'b0; incr = 1'b0; writeback = 1'b0;
        base_reg = '0; base_addr = '0; reg_list = '0;
    endtask

    task automatic run_op(input string name, input logic ld, input logic inc, input logic wbk,
                          input logic [3:0] br, input logic [31:0] ba, input logic [15:0] lst);
        logic [31:0] rf0[16], rf_m[16];
        logic [31:0] mem0[256], mem_m[256];
        int regs[$];
        int n, wbc;
        logic [31:0] a0, fin, a;
        logic supp;
        logic [108:0] got, exp, msk;
        logic e_busy, e_done, e_mwe, e_rwe, e_pc;
        logic [31:0] e_maddr, e_mwd, e_rwd;
        logic [3:0] e_ra, e_rwa;
        logic c_mwe, c_rwe;
        logic [31:0] c_maddr, c_mwd, c_rwd;
        logic [3:0] c_rwa;

        rf0 = rf; mem0 = mem;
        n = 0;
        for (int i = 0; i < 16; i++) if (lst[i]) begin regs.push_back(i); n++; end
        a0   = inc ? ba : ba - 32'(4 * n);
        fin  = inc ? ba + 32'(4 * n) : a0;
        supp = ld && lst[br];
        wbc  = (n > 0 && wbk) ? 1 : 0;
        rf_m = rf0; mem_m = mem0;
        for (int k = 0; k < n; k++) begin
            a = a0 + 32'(4 * k);
            if (ld) rf_m[regs[k]] = mem0[a[9:2]];
            else    mem_m[a[9:2]] = rf0[regs[k]];
        end
        if (wbc == 1 && !supp) rf_m[br] = fin;

        @(negedge clk);
        start = 1'b1; is_load = ld; incr = inc; writeback = wbk;
        base_reg = br; base_addr = ba; reg_list = lst;
        @(posedge clk);
        #1;
        // Operands must have been captured at start; scramble them afterwards.
        start = 1'b0; is_load = ~ld; incr = ~inc; writeback = ~wbk;
        base_reg = 4'($urandom); base_addr = $urandom; reg_list = 16'($urandom);

        for (int c = 1; c <= n + wbc + 3; c++) begin
            @(negedge clk);
            e_busy = (c <= n + wbc); e_done = (c == n + wbc + 1);
            e_mwe = 0; e_rwe = 0; e_pc = 0; e_maddr = 0; e_mwd = 0; e_rwd = 0; e_ra = 0; e_rwa = 0;
            msk = '1;
            if (c <= n) begin
                a = a0 + 32'(4 * (c - 1));
                e_maddr = a;
                if (ld) begin
                    e_rwe = 1; e_rwa = 4'(regs[c - 1]); e_rwd = mem0[a[9:2]];
                    e_pc = (regs[c - 1] == 15);
                end else begin
                    e_mwe = 1; e_ra = 4'(regs[c - 1]); e_mwd = rf0[regs[c - 1]];
                end
            end else if (wbc == 1 && c == n + 1) begin
                e_rwe = !supp; e_rwa = br; e_rwd = fin; e_pc = !supp && (br == 4'hF);
                if (supp) msk[36:1] = '0;
            end
            exp = {e_busy, e_done, e_mwe, e_maddr, e_mwd, e_ra, e_rwe, e_rwa, e_rwd, e_pc};
            got = obs();
            tests++;
            if ((got & msk) !== (exp & msk)) begin
                fails++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, c, got & msk, exp & msk);
            end
            c_mwe = mem_we; c_maddr = mem_addr; c_mwd = mem_wd;
            c_rwe = rf_we; c_rwa = rf_wa; c_rwd = rf_wd;
            @(posedge clk);
            if (c_mwe) mem[c_maddr[9:2]] = c_mwd;
            if (c_rwe) rf[c_rwa] = c_rwd;
        end

        for (int i = 0; i < 16; i++) begin
            tests++;
            if (rf[i] !== rf_m[i]) begin
                fails++;
                $display("FAIL %s rf[%0d]: got %h expected %h", name, i, rf[i], rf_m[i]);
            end
        end
        for (int i = 0; i < 256; i++) begin
            tests++;
            if (mem[i] !== mem_m[i]) begin
                fails++;
                $display("FAIL %s mem word %0d: got %h expected %h", name, i, mem[i], mem_m[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (obs() !== '0) begin
            fails++;
            $display("FAIL reset outputs: got %h expected 0", obs());
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] expect_v;
        init_env();
        rf[0] = 32'hF; rf[1] = 32'hF0;
        run_op("stm_ia", 0, 1, 0, 4'd0, 32'h100, 16'h0003);
        tests++;
        if (mem[8'h40] !== 32'hF || mem[8'h41] !== 32'hF0) begin
            fails++;
            $display("FAIL stm_ia words: got %h %h expected f f0", mem[8'h40], mem[8'h41]);
        end

        init_env();
        expect_v = mem[7];
        run_op("ldm_db_wb", 1, 0, 1, 4'd4, 32'h20, 16'h8006);
        tests++;
        if (rf[4] !== 32'h14 || rf[15] !== expect_v) begin
            fails++;
            $display("FAIL ldm_db_wb regs: got r4=%h r15=%h expected 14 %h", rf[4], rf[15], expect_v);
        end

        init_env();
        expect_v = mem[8'h11];
        run_op("ldm_ia_base_in_list", 1, 1, 1, 4'd4, 32'h40, 16'h0011);
        tests++;
        if (rf[4] !== expect_v) begin
            fails++;
            $display("FAIL ldm_ia_base_in_list r4: got %h expected %h", rf[4], expect_v);
        end

        init_env();
        run_op("empty_list", 0, 1, 1, 4'd3, 32'h80, 16'h0000);
        run_op("empty_list_ld", 1, 0, 1, 4'd15, 32'h80, 16'h0000);
    endtask

    task automatic test_wrap();
        init_env();
        run_op("stm_wrap", 0, 1, 1, 4'd9, 32'hFFFF_FFFC, 16'h0003);
        tests++;
        if (mem[255] !== rf[0] || mem[0] !== rf[1] || rf[9] !== 32'h4) begin
            fails++;
            $display("FAIL stm_wrap: got %h %h r9=%h expected %h %h 4", mem[255], mem[0], rf[9], rf[0], rf[1]);
        end
    endtask

    task automatic test_random();
        logic [15:0] lst;
        for (int t = 0; t < 24; t++) begin
            init_env();
            case ($urandom_range(0, 5))
                0:       lst = 16'h0000;
                1:       lst = 16'hFFFF;
                default: lst = 16'($urandom);
            endcase
            run_op("random", 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                   {$urandom, 2'b00} & 32'hFFFF_FFFC, lst);
        end
    endtask

    task automatic test_back_to_back();
        init_env();
        run_op("b2b_first", 0, 0, 1, 4'd13, 32'h300, 16'h00F0);
        run_op("b2b_second", 1, 1, 1, 4'd13, 32'h300 - 32'd16, 16'h0F00);
    endtask

    task automatic test_abort();
        logic [31:0] untouched;
        logic c_mwe;
        logic [31:0] c_maddr, c_mwd;
        init_env();
        untouched = mem[8'h83];
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; incr = 1'b1; writeback = 1'b1;
        base_reg = 4'd5; base_addr = 32'h200; reg_list = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; is_load = 1'b1; reg_list = 16'h0001; base_addr = 32'h0;
            end
            if (c == 3) begin
                tests++;
                if (ra !== 4'd2 || mem_addr !== 32'h208 || mem_we !== 1'b1) begin
                    fails++;
                    $display("FAIL abort ignore start: got ra=%0d addr=%h we=%b expected 2 208 1", ra, mem_addr, mem_we);
                end
                start = 1'b0;
                reset = 1'b1;
            end
            c_mwe = mem_we; c_maddr = mem_addr; c_mwd = mem_wd;
            @(posedge clk);
            if (c_mwe) mem[c_maddr[9:2]] = c_mwd;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (obs() !== '0) begin
                fails++;
                $display("FAIL abort outputs cycle %0d: got %h expected 0", c, obs());
            end
            if (c == 1) reset = 1'b0;
            @(posedge clk);
        end
        tests++;
        if (mem[8'h80] !== rf[0] || mem[8'h81] !== rf[1] || mem[8'h82] !== rf[2] || mem[8'h83] !== untouched) begin
            fails++;
            $display("FAIL abort committed words: got %h %h %h %h expected %h %h %h %h",
                     mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83], rf[0], rf[1], rf[2], untouched);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wrap();
        test_back_to_back();
        test_random();
        test_abort();
        run_op("after_abort", 1, 1, 0, 4'd0, 32'h40, 16'h8001);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
